// File: rtl/bat_datapath.sv
// Bus-centred datapath: PC, MAR, RAM, IR and eight general registers sharing one OR-combined bus,
// with sticky multiple-driver detection and a saturating conflict counter.
module bat_datapath #(
   parameter int unsigned ADDR_W = 8
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              PC_INC,
   input  logic              PC_RW,
   input  logic              PC_EN,
   input  logic              MAR_LOAD,
   input  logic              MAR_EN,
   input  logic              RAM_RW,
   input  logic              RAM_EN,
   input  logic              IR_LOAD,
   input  logic              IR_EN,
   input  logic [7:0]        REGS_INC,
   input  logic [7:0]        REGS_RW,
   input  logic [7:0]        REGS_EN,
   input  logic              ALU_EN,
   input  logic [15:0]       ALU_RESULT,
   input  logic              LOAD_WE,
   input  logic [ADDR_W-1:0] LOAD_ADDR,
   input  logic [15:0]       LOAD_DATA,
   output logic [15:0]       INSTR,
   output logic [15:0]       ALU_A,
   output logic [15:0]       ALU_B,
   output logic [15:0]       OUT_REG,
   output logic [15:0]       BUS,
   output logic              BUS_CONFLICT,
   output logic [7:0]        CONFLICT_CNT
);

   localparam int unsigned DATA_W = 16;
   localparam int unsigned NREGS  = 8;
   localparam int unsigned DEPTH  = 1 << ADDR_W;
   localparam logic [DATA_W-1:0] IR_NOP = 16'hF000;

   logic [ADDR_W-1:0] pc;
   logic [ADDR_W-1:0] mar;
   logic [DATA_W-1:0] ir;
   logic [DATA_W-1:0] regs [NREGS];
   logic [DATA_W-1:0] mem  [DEPTH];
   logic              conflict_q;
   logic [7:0]        cnt_q;

   logic [DATA_W-1:0] bus_c;
   logic [3:0]        n_drv_c;
   logic              ram_wr_c;
   logic              conflict_c;

   // Bus is the OR of every active driver; the driver count feeds conflict detection.
   always_comb begin
      bus_c   = '0;
      n_drv_c = '0;
      if (PC_EN && PC_RW) begin
         bus_c   = bus_c | 16'(pc);
         n_drv_c = n_drv_c + 4'd1;
      end
      if (RAM_EN && RAM_RW) begin
         bus_c   = bus_c | mem[mar];
         n_drv_c = n_drv_c + 4'd1;
      end
      if (IR_EN) begin
         bus_c   = bus_c | 16'(ir[ADDR_W-1:0]);
         n_drv_c = n_drv_c + 4'd1;
      end
      for (int unsigned i = 0; i < NREGS; i++) begin
         if (REGS_EN[i] && REGS_RW[i]) begin
            bus_c   = bus_c | regs[i];
            n_drv_c = n_drv_c + 4'd1;
         end
      end
      if (ALU_EN) begin
         bus_c   = bus_c | ALU_RESULT;
         n_drv_c = n_drv_c + 4'd1;
      end
   end

   // A preload colliding with a bus-side RAM write is also treated as a conflict.
   assign ram_wr_c   = RAM_EN && !RAM_RW;
   assign conflict_c = (n_drv_c > 4'd1) || (LOAD_WE && ram_wr_c);

   // RAM has no reset; the preload port stays live during reset and beats bus writes.
   always_ff @(posedge CLK) begin
      if (LOAD_WE) begin
         mem[LOAD_ADDR] <= LOAD_DATA;
      end else if (RST && ram_wr_c) begin
         mem[mar] <= bus_c;
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         pc  <= '0;
         mar <= '0;
         ir  <= IR_NOP;
      end else begin
         if (PC_EN && !PC_RW) begin
            pc <= bus_c[ADDR_W-1:0];
         end else if (PC_INC) begin
            pc <= pc + ADDR_W'(1);
         end
         if (MAR_EN && MAR_LOAD) begin
            mar <= bus_c[ADDR_W-1:0];
         end
         if (IR_LOAD) begin
            ir <= bus_c;
         end
      end
   end

   // Register load beats increment; increment works even while the register is disabled.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         for (int unsigned i = 0; i < NREGS; i++) begin
            regs[i] <= '0;
         end
      end else begin
         for (int unsigned i = 0; i < NREGS; i++) begin
            if (REGS_EN[i] && !REGS_RW[i]) begin
               regs[i] <= bus_c;
            end else if (REGS_INC[i]) begin
               regs[i] <= regs[i] + 16'd1;
            end
         end
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         conflict_q <= 1'b0;
         cnt_q      <= '0;
      end else if (conflict_c) begin
         conflict_q <= 1'b1;
         if (cnt_q != 8'hFF) begin
            cnt_q <= cnt_q + 8'd1;
         end
      end
   end

   assign BUS          = bus_c;
   assign INSTR        = ir;
   assign ALU_A        = regs[0];
   assign ALU_B        = regs[1];
   assign OUT_REG      = regs[7];
   assign BUS_CONFLICT = conflict_q;
   assign CONFLICT_CNT = cnt_q;

endmodule

// File: tb/tb_bat_datapath.sv
// Directed bench for bat_datapath: a transaction-level model checked every negedge,
// plus hand-computed expectations for the key scenarios.
module tb_bat_datapath;

   localparam int unsigned AW = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          pc_inc, pc_rw, pc_en, mar_load, mar_en, ram_rw, ram_en, ir_load, ir_en;
   logic [7:0]    regs_inc, regs_rw, regs_en;
   logic          alu_en;
   logic [15:0]   alu_result;
   logic          load_we;
   logic [AW-1:0] load_addr;
   logic [15:0]   load_data;
   logic [15:0]   instr, alu_a, alu_b, out_reg, bus;
   logic          bus_conflict;
   logic [7:0]    conflict_cnt;

   bat_datapath #(.ADDR_W(AW)) dut (
      .CLK(clk), .RST(rst),
      .PC_INC(pc_inc), .PC_RW(pc_rw), .PC_EN(pc_en),
      .MAR_LOAD(mar_load), .MAR_EN(mar_en),
      .RAM_RW(ram_rw), .RAM_EN(ram_en),
      .IR_LOAD(ir_load), .IR_EN(ir_en),
      .REGS_INC(regs_inc), .REGS_RW(regs_rw), .REGS_EN(regs_en),
      .ALU_EN(alu_en), .ALU_RESULT(alu_result),
      .LOAD_WE(load_we), .LOAD_ADDR(load_addr), .LOAD_DATA(load_data),
      .INSTR(instr), .ALU_A(alu_a), .ALU_B(alu_b), .OUT_REG(out_reg),
      .BUS(bus), .BUS_CONFLICT(bus_conflict), .CONFLICT_CNT(conflict_cnt)
   );

   always #5 clk = ~clk;

   // Model state
   logic [AW-1:0] m_pc, m_mar;
   logic [15:0]   m_ir;
   logic [15:0]   m_reg [8];
   logic [15:0]   m_mem [256];
   bit            m_val [256];
   bit            m_conf;
   int            m_cnt;

   int checks   = 0;
   int failures = 0;
   bit chk_en   = 1'b0;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void model_reset();
      m_pc = '0; m_mar = '0; m_ir = 16'hF000; m_conf = 1'b0; m_cnt = 0;
      for (int i = 0; i < 8; i++) m_reg[i] = '0;
   endfunction

   // Bus value from the current model state and control inputs.
   function automatic void model_bus(output logic [15:0] b, output int n, output bit known);
      b = '0; n = 0; known = 1'b1;
      if (pc_en && pc_rw) begin b = b | {8'h00, m_pc}; n++; end
      if (ram_en && ram_rw) begin b = b | m_mem[m_mar]; n++; known = m_val[m_mar]; end
      if (ir_en) begin b = b | {8'h00, m_ir[7:0]}; n++; end
      for (int i = 0; i < 8; i++)
         if (regs_en[i] && regs_rw[i]) begin b = b | m_reg[i]; n++; end
      if (alu_en) begin b = b | alu_result; n++; end
   endfunction

   function automatic void model_step();
      logic [15:0] b;
      int          n;
      bit          k;
      bit          wr;
      model_bus(b, n, k);
      wr = ram_en && !ram_rw;
      if (rst) begin
         if (wr && !load_we) begin m_mem[m_mar] = b; m_val[m_mar] = 1'b1; end
         if (pc_en && !pc_rw) m_pc = b[7:0];
         else if (pc_inc) m_pc = m_pc + 8'd1;
         if (mar_en && mar_load) m_mar = b[7:0];
         if (ir_load) m_ir = b;
         for (int i = 0; i < 8; i++) begin
            if (regs_en[i] && !regs_rw[i]) m_reg[i] = b;
            else if (regs_inc[i]) m_reg[i] = m_reg[i] + 16'd1;
         end
         if (n >= 2 || (load_we && wr)) begin
            m_conf = 1'b1;
            if (m_cnt < 255) m_cnt++;
         end
      end
      if (load_we) begin m_mem[load_addr] = load_data; m_val[load_addr] = 1'b1; end
   endfunction

   // Every-cycle comparison against the model
   logic [15:0] cmp_b;
   int          cmp_n;
   bit          cmp_k;
   always @(negedge clk) begin
      if (chk_en) begin
         model_bus(cmp_b, cmp_n, cmp_k);
         check("instr", instr, m_ir);
         check("alu_a", alu_a, m_reg[0]);
         check("alu_b", alu_b, m_reg[1]);
         check("out_reg", out_reg, m_reg[7]);
         if (cmp_k) check("bus", bus, cmp_b);
         check("bus_conflict", 16'(bus_conflict), 16'(m_conf));
         check("conflict_cnt", 16'(conflict_cnt), 16'(m_cnt));
      end
   end

   task automatic idle();
      pc_inc = 0; pc_rw = 0; pc_en = 0; mar_load = 0; mar_en = 0;
      ram_rw = 0; ram_en = 0; ir_load = 0; ir_en = 0;
      regs_inc = '0; regs_rw = '0; regs_en = '0;
      alu_en = 0; alu_result = '0; load_we = 0; load_addr = '0; load_data = '0;
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
      #1;
   endtask

   task automatic alu_drive(input logic [15:0] v);
      alu_en = 1; alu_result = v;
   endtask

   initial begin
      idle();
      #1 rst = 1'b0;
      model_reset();
      chk_en = 1'b1;
      #1;
      check("reset_instr", instr, 16'hF000);
      check("reset_alu_a", alu_a, 16'h0000);
      check("reset_bus", bus, 16'h0000);
      check("reset_cnt", 16'(conflict_cnt), 16'h0000);

      // Preload program words while held in reset
      load_we = 1; load_addr = 8'h00; load_data = 16'h7F81; tick();
      load_addr = 8'h01; load_data = 16'h1111; tick();
      load_addr = 8'h05; load_data = 16'h0BAD; tick();
      idle(); tick();
      rst = 1'b1; tick();

      // Fetch: PC -> MAR, then RAM[MAR] -> IR with PC increment
      pc_en = 1; pc_rw = 1; mar_en = 1; mar_load = 1; tick();
      idle(); ram_en = 1; ram_rw = 1; ir_load = 1; pc_inc = 1; tick();
      check("fetch_instr", instr, 16'h7F81);
      idle(); pc_en = 1; pc_rw = 1; #1;
      check("fetch_pc", bus, 16'h0001);
      tick();

      // Register-to-register transfer
      idle(); alu_drive(16'h0055); regs_en = 8'h04; tick();
      idle(); regs_en = 8'h05; regs_rw = 8'hFE; tick();
      check("reg0_copy", alu_a, 16'h0055);
      check("reg0_copy_noconf", 16'(bus_conflict), 16'h0000);
      idle(); regs_en = 8'h86; regs_rw = 8'h04; tick();
      check("multi_load_b", alu_b, 16'h0055);
      check("multi_load_out", out_reg, 16'h0055);

      // Wraparound of PC and registers; load beats increment
      idle(); alu_drive(16'h00FF); pc_en = 1; tick();
      idle(); pc_inc = 1; tick();
      idle(); pc_en = 1; pc_rw = 1; #1;
      check("pc_wrap", bus, 16'h0000);
      idle(); alu_drive(16'h0010); pc_en = 1; pc_inc = 1; tick();
      idle(); pc_en = 1; pc_rw = 1; #1;
      check("pc_load_wins", bus, 16'h0010);
      idle(); alu_drive(16'hFFFF); regs_en = 8'h80; tick();
      idle(); regs_inc = 8'h80; tick();
      check("out_wrap", out_reg, 16'h0000);

      // IR low bits drive PC; disabled MAR ignores MAR_LOAD; self-load is not a conflict
      idle(); alu_drive(16'h4023); ir_load = 1; tick();
      idle(); ir_en = 1; pc_en = 1; tick();
      idle(); pc_en = 1; pc_rw = 1; #1;
      check("pc_from_ir", bus, 16'h0023);
      idle(); ir_en = 1; ir_load = 1; tick();
      check("ir_selfload", instr, 16'h0023);
      check("ir_selfload_noconf", 16'(bus_conflict), 16'h0000);
      idle(); alu_drive(16'h0001); mar_load = 1; tick();
      idle(); ram_en = 1; ram_rw = 1; #1;
      check("mar_hold", bus, 16'h7F81);
      tick();

      // RAM write via bus, then read-old-data while preload hits the same address
      idle(); alu_drive(16'h0005); mar_en = 1; mar_load = 1; tick();
      idle(); alu_drive(16'h2222); ram_en = 1; tick();
      idle(); ram_en = 1; ram_rw = 1; load_we = 1; load_addr = 8'h05; load_data = 16'h3333; #1;
      check("ram_old_data", bus, 16'h2222);
      tick();
      idle(); ram_en = 1; ram_rw = 1; #1;
      check("ram_new_data", bus, 16'h3333);
      tick();

      // Conflicts: ALU + reg 1, preload vs bus write, then saturation
      idle(); alu_drive(16'h000F); regs_en = 8'h02; tick();
      idle(); alu_drive(16'h00F0); regs_en = 8'h02; regs_rw = 8'h02; #1;
      check("conflict_bus", bus, 16'h00FF);
      tick();
      check("conflict_flag", 16'(bus_conflict), 16'h0001);
      check("conflict_cnt1", 16'(conflict_cnt), 16'h0001);
      idle(); alu_drive(16'h4444); ram_en = 1; load_we = 1; load_addr = 8'h05; load_data = 16'h5555; tick();
      check("loadwe_conflict_cnt", 16'(conflict_cnt), 16'h0002);
      idle(); ram_en = 1; ram_rw = 1; #1;
      check("loadwe_wins", bus, 16'h5555);
      tick();
      idle(); alu_drive(16'h00F0); regs_en = 8'h02; regs_rw = 8'h02;
      repeat (300) tick();
      check("conflict_sat", 16'(conflict_cnt), 16'h00FF);

      // Reset mid-cycle with a register load pending
      idle(); alu_drive(16'h1234); regs_en = 8'h01; #2;
      rst = 1'b0;
      model_reset();
      #1;
      check("midreset_reg0", alu_a, 16'h0000);
      check("midreset_ir", instr, 16'hF000);
      tick();
      check("midreset_suppressed", alu_a, 16'h0000);
      idle(); rst = 1'b1; tick();
      check("midreset_conf_clr", 16'(bus_conflict), 16'h0000);
      idle(); ram_en = 1; ram_rw = 1; #1;
      check("midreset_ram_kept", bus, 16'h7F81);
      tick();

      idle();
      chk_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
